// File: rtl/arp_tx_gen.sv
// arp_tx_gen: GMII ARP request/reply frame generator with CRC-32 FCS, zero pad and enforced inter-frame gap
module arp_tx_gen #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [15:0] tx_op,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [7:0]  gmii_txd,
  output logic        gmii_txen
);
  localparam int MAXL = MIN_PAYLOAD > IFG_BYTES ? MIN_PAYLOAD : IFG_BYTES;
  localparam int CW = $clog2(MAXL);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, HEAD = 3'd2, DATA = 3'd3, FCS = 3'd4, IFG = 3'd5;
  logic [2:0] state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt, len_m1;
  logic [15:0] op_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q, crc;
  logic accept, last, is_req, nxt_ready;
  logic [111:0] hdr;
  logic [223:0] body;
  logic [7:0] nxt_byte;
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    accept = tx_start & tx_ready;
    len_m1 = state == PRE ? CW'(7) : state == HEAD ? CW'(13) : state == DATA ? CW'(MIN_PAYLOAD - 1) :
             state == FCS ? CW'(3) : CW'(IFG_BYTES - 1);
    last = cnt == len_m1;
    nxt_state = accept ? PRE : (state == IDLE || !last) ? state : state == IFG ? IDLE : state + 3'd1;
    nxt_cnt = (accept || state == IDLE || last) ? '0 : cnt + 1'b1;
    nxt_ready = nxt_state == IDLE || (nxt_state == IFG && nxt_cnt == CW'(IFG_BYTES - 1));
    is_req = op_q == 16'd1;
    hdr = {is_req ? 48'hFFFF_FFFF_FFFF : mac_q, BOARD_MAC, 16'h0806};
    body = {16'h0001, 16'h0800, 8'h06, 8'h04, op_q, BOARD_MAC, BOARD_IP, is_req ? 48'h0 : mac_q, ip_q};
    nxt_byte = nxt_state == PRE ? (nxt_cnt == CW'(7) ? 8'hD5 : 8'h55) :
               nxt_state == HEAD ? 8'(hdr >> (8 * (13 - int'(nxt_cnt)))) :
               nxt_state == DATA ? (nxt_cnt < CW'(28) ? 8'(body >> (8 * (27 - int'(nxt_cnt)))) : 8'h00) :
               nxt_state == FCS ? 8'(~crc >> {nxt_cnt[1:0], 3'b000}) : 8'h00;
  end
  always_ff @(posedge clk)
    if (accept) begin
      op_q <= tx_op;
      mac_q <= dst_mac;
      ip_q <= dst_ip;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      crc <= '1;
      gmii_txd <= '0;
      gmii_txen <= 1'b0;
      tx_done <= 1'b0;
      tx_busy <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      gmii_txd <= nxt_byte;
      gmii_txen <= nxt_state inside {PRE, HEAD, DATA, FCS};
      tx_done <= state == FCS && last;
      tx_ready <= nxt_ready;
      tx_busy <= !nxt_ready;
      crc <= accept ? '1 : (nxt_state == HEAD || nxt_state == DATA) ? crc_upd(crc, nxt_byte) : crc;
    end
endmodule

// File: tb/tb_arp_tx_gen.sv
// tb_arp_tx_gen: directed checks of ARP frame bytes, FCS residue, handshake timing, back-to-back, latching, reset and a parameter variant
`timescale 1ns/1ps
module tb_arp_tx_gen;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [15:0] tx_op = 16'd2;
  logic [47:0] dst_mac = 48'h00_0A_35_01_FE_C0;
  logic [31:0] dst_ip = {8'd192, 8'd168, 8'd1, 8'd102};
  logic rdy_a, busy_a, done_a, txen_a, rdy_b, busy_b, done_b, txen_b;
  logic [7:0] txd_a, txd_b;
  int tests = 0, fails = 0, cyc = 0;
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  arp_tx_gen u_a (
    .clk(clk), .rst(rst), .tx_start(start_a), .tx_op(tx_op), .dst_mac(dst_mac), .dst_ip(dst_ip),
    .tx_ready(rdy_a), .tx_busy(busy_a), .tx_done(done_a), .gmii_txd(txd_a), .gmii_txen(txen_a)
  );
  arp_tx_gen #(.BOARD_IP({8'd10, 8'd0, 8'd0, 8'd2}), .MIN_PAYLOAD(60), .IFG_BYTES(20)) u_b (
    .clk(clk), .rst(rst), .tx_start(start_b), .tx_op(tx_op), .dst_mac(dst_mac), .dst_ip(dst_ip),
    .tx_ready(rdy_b), .tx_busy(busy_b), .tx_done(done_b), .gmii_txd(txd_b), .gmii_txen(txen_b)
  );
  logic [7:0] cap_a[$], cap_b[$], ref_a[$];
  int rise_a[$], gap_a[$], rrun_a[$], rise_b[$], gap_b[$];
  int ndone_a = 0, done_cyc_a = 0, low_a = 0, rl_a = 0, ndone_b = 0, low_b = 0;
  logic pen_a = 1'b0, prdy_a = 1'b1, pen_b = 1'b0;
  always @(negedge clk) begin
    if (txen_a) cap_a.push_back(txd_a);
    if (txen_a && !pen_a) begin rise_a.push_back(cyc); gap_a.push_back(low_a); end
    low_a = txen_a ? 0 : low_a + 1;
    if (rdy_a && !prdy_a) rrun_a.push_back(rl_a);
    rl_a = rdy_a ? 0 : rl_a + 1;
    if (done_a) begin ndone_a++; done_cyc_a = cyc; end
    pen_a = txen_a;
    prdy_a = rdy_a;
  end
  always @(negedge clk) begin
    if (txen_b) cap_b.push_back(txd_b);
    if (txen_b && !pen_b) begin rise_b.push_back(cyc); gap_b.push_back(low_b); end
    low_b = txen_b ? 0 : low_b + 1;
    if (done_b) ndone_b++;
    pen_b = txen_b;
  end
  logic [7:0] gold [50] = '{
    8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
    8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h06,
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
    8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h0A,
    8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0, 8'hC0, 8'hA8, 8'h01, 8'h66};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
    return r;
  endfunction
  task automatic chk_fcs(input string tag, input logic [7:0] q[$], input int n);
    logic [31:0] c = '1, r;
    for (int i = 8; i < n - 4; i++) c = crc_byte(c, q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) chk($sformatf("%s fcs%0d", tag, i), 64'(q[n - 4 + i]), 64'(c[8 * i +: 8]));
    c = '1;
    for (int i = 8; i < n; i++) c = crc_byte(c, q[i]);
    r = {<<{c}};
    chk({tag, " residue"}, 64'(r), 64'h0000_0000_C704_DD7B);
  endtask
  task automatic clr();
    cap_a.delete(); rise_a.delete(); gap_a.delete(); rrun_a.delete();
    cap_b.delete(); rise_b.delete(); gap_b.delete();
    ndone_a = 0; ndone_b = 0;
  endtask
  task automatic wait_rdy(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(rdy_a && rdy_b) && n < 1000) begin @(negedge clk); n++; end
    chk({tag, " ready timeout"}, 64'(n < 1000), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic pulse_a();
    start_a = 1'b1;
    @(posedge clk) #1 start_a = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst txen", 64'(txen_a), 64'd0);
    chk("rst txd", 64'(txd_a), 64'd0);
    chk("rst done", 64'(done_a), 64'd0);
    chk("rst busy", 64'(busy_a), 64'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready", 64'(rdy_a), 64'd1);
    chk("post-rst txen", 64'(txen_a), 64'd0);
    @(posedge clk) #1;
    clr();
    pulse_a();
    @(negedge clk);
    chk("accept txen", 64'(txen_a), 64'd1);
    chk("accept txd", 64'(txd_a), 64'h55);
    chk("accept ready", 64'(rdy_a), 64'd0);
    chk("accept busy", 64'(busy_a), 64'd1);
    wait_rdy("reply");
    chk("reply len", 64'(cap_a.size()), 64'd72);
    for (int i = 0; i < 50; i++) chk($sformatf("reply b%0d", i), 64'(cap_a[i]), 64'(gold[i]));
    for (int i = 50; i < 68; i++) chk($sformatf("reply pad%0d", i), 64'(cap_a[i]), 64'd0);
    chk_fcs("reply", cap_a, 72);
    chk("reply ndone", 64'(ndone_a), 64'd1);
    chk("reply done cyc", 64'(done_cyc_a - rise_a[0]), 64'd72);
    ref_a = cap_a;
    clr();
    tx_op = 16'd1;
    pulse_a();
    wait_rdy("request");
    tx_op = 16'd2;
    chk("req len", 64'(cap_a.size()), 64'd72);
    for (int i = 8; i < 14; i++) chk($sformatf("req eth dst%0d", i), 64'(cap_a[i]), 64'hFF);
    for (int i = 40; i < 46; i++) chk($sformatf("req tgt mac%0d", i), 64'(cap_a[i]), 64'd0);
    chk("req op", 64'({cap_a[28], cap_a[29]}), 64'h0001);
    for (int i = 46; i < 50; i++) chk($sformatf("req tgt ip%0d", i), 64'(cap_a[i]), 64'(gold[i]));
    chk_fcs("req", cap_a, 72);
    clr();
    start_a = 1'b1;
    repeat (300) @(posedge clk);
    #1 start_a = 1'b0;
    wait_rdy("b2b");
    chk("b2b frames", 64'(rise_a.size()), 64'd4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("b2b spacing%0d", i), 64'(rise_a[i] - rise_a[i - 1]), 64'd84);
      chk($sformatf("b2b gap%0d", i), 64'(gap_a[i]), 64'd12);
    end
    chk("b2b bytes", 64'(cap_a.size()), 64'd288);
    chk("b2b ndone", 64'(ndone_a), 64'd4);
    clr();
    pulse_a();
    repeat (19) @(posedge clk);
    #1 dst_mac = 48'h12_34_56_78_9A_BC;
    dst_ip = 32'h0102_0304;
    start_a = 1'b1;
    @(negedge clk);
    chk("latch ready low", 64'(rdy_a), 64'd0);
    @(posedge clk) #1 start_a = 1'b0;
    dst_mac = 48'h00_0A_35_01_FE_C0;
    dst_ip = {8'd192, 8'd168, 8'd1, 8'd102};
    wait_rdy("latch");
    chk("latch frames", 64'(rise_a.size()), 64'd1);
    for (int i = 8; i < 14; i++) chk($sformatf("latch eth dst%0d", i), 64'(cap_a[i]), 64'(gold[i]));
    for (int i = 40; i < 50; i++) chk($sformatf("latch tgt%0d", i), 64'(cap_a[i]), 64'(gold[i]));
    chk("latch ready-low run", 64'(rrun_a[rrun_a.size() - 1]), 64'd83);
    clr();
    pulse_a();
    n = 0;
    while (cap_a.size() < 31 && n < 200) begin @(negedge clk); n++; end
    chk("rst-mid reach byte30", 64'(n < 200), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst-mid txen", 64'(txen_a), 64'd0);
    chk("rst-mid txd", 64'(txd_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst-mid ready", 64'(rdy_a), 64'd1);
    repeat (100) @(negedge clk);
    chk("rst-mid no done", 64'(ndone_a), 64'd0);
    @(posedge clk) #1;
    clr();
    pulse_a();
    wait_rdy("after rst");
    chk("after rst len", 64'(cap_a.size()), 64'd72);
    for (int i = 0; i < 72; i++) chk($sformatf("after rst b%0d", i), 64'(cap_a[i]), 64'(ref_a[i]));
    clr();
    start_b = 1'b1;
    repeat (150) @(posedge clk);
    #1 start_b = 1'b0;
    wait_rdy("variant");
    chk("var frames", 64'(rise_b.size()), 64'd2);
    chk("var spacing", 64'(rise_b[1] - rise_b[0]), 64'd106);
    chk("var gap", 64'(gap_b[1]), 64'd20);
    chk("var bytes", 64'(cap_b.size()), 64'd172);
    chk("var ndone", 64'(ndone_b), 64'd2);
    chk("var sender ip", 64'({cap_b[36], cap_b[37], cap_b[38], cap_b[39]}), 64'h0A00_0002);
    for (int i = 8; i < 14; i++) chk($sformatf("var eth dst%0d", i), 64'(cap_b[i]), 64'(gold[i]));
    for (int i = 50; i < 82; i++) chk($sformatf("var pad%0d", i), 64'(cap_b[i]), 64'd0);
    chk_fcs("var", cap_b, 86);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
